// File: rtl/famicom_pad_ports_if.sv
// Controller-port bus: CPU-side strobes and raw buttons in, serial data and status out.
interface famicom_pad_ports_if #(
  parameter int NUM_PORTS = 2,
  parameter int SHIFT_LEN = 8
);
  logic                           OUT0;
  logic [NUM_PORTS-1:0]           nINP;
  logic [NUM_PORTS*SHIFT_LEN-1:0] BTN;
  logic [NUM_PORTS-1:0]           SDO;
  logic [NUM_PORTS-1:0]           SDO_OE;
  logic [NUM_PORTS-1:0]           EMPTY;

  modport master (
    output OUT0, nINP, BTN,
    input  SDO, SDO_OE, EMPTY
  );

  modport slave (
    input  OUT0, nINP, BTN,
    output SDO, SDO_OE, EMPTY
  );
endinterface

// File: rtl/famicom_pad_ports.sv
// Serial controller-port engine: per-port parallel-load shift registers with
// synchronised latch/read strobes, fill-on-shift and exhaustion flags.
module famicom_pad_ports #(
  parameter int NUM_PORTS   = 2,
  parameter int SHIFT_LEN   = 8,
  parameter bit FILL_BIT    = 1'b1,
  parameter bit INVERT_OUT  = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  famicom_pad_ports_if.slave   bus
);
  localparam int NB = NUM_PORTS * SHIFT_LEN;
  localparam int CW = $clog2(SHIFT_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SHIFT_LEN);

  logic [SYNC_STAGES-1:0]                 out0_sync_reg;
  logic [SYNC_STAGES-1:0][NUM_PORTS-1:0]  ninp_sync_reg;
  logic [SYNC_STAGES-1:0][NB-1:0]         btn_sync_reg;

  logic                 strobe_s;
  logic [NUM_PORTS-1:0] ninp_s;
  logic [NB-1:0]        btn_s;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out0_sync_reg <= '0;
      ninp_sync_reg <= '1;
      btn_sync_reg  <= '0;
    end else begin
      out0_sync_reg <= {out0_sync_reg[SYNC_STAGES-2:0], bus.OUT0};
      ninp_sync_reg <= {ninp_sync_reg[SYNC_STAGES-2:0], bus.nINP};
      btn_sync_reg  <= {btn_sync_reg[SYNC_STAGES-2:0], bus.BTN};
    end
  end

  assign strobe_s = out0_sync_reg[SYNC_STAGES-1];
  assign ninp_s   = ninp_sync_reg[SYNC_STAGES-1];
  assign btn_s    = btn_sync_reg[SYNC_STAGES-1];

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [SHIFT_LEN-1:0] sr_reg, sr_next;
      logic [CW-1:0]        cnt_reg, cnt_next;
      logic                 ninp_d_reg;
      logic                 rise;

      assign rise = ninp_s[gi] & ~ninp_d_reg;

      // Load dominates: a read edge landing while the strobe is high is dropped.
      always_comb begin
        sr_next  = sr_reg;
        cnt_next = cnt_reg;
        if (strobe_s) begin
          sr_next  = btn_s[gi*SHIFT_LEN +: SHIFT_LEN];
          cnt_next = '0;
        end else if (rise) begin
          sr_next  = {FILL_BIT, sr_reg[SHIFT_LEN-1:1]};
          cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CW'(1);
        end
      end

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          sr_reg     <= '0;
          cnt_reg    <= '0;
          ninp_d_reg <= 1'b1;
        end else begin
          sr_reg     <= sr_next;
          cnt_reg    <= cnt_next;
          ninp_d_reg <= ninp_s[gi];
        end
      end

      assign bus.SDO[gi]    = sr_reg[0] ^ INVERT_OUT;
      assign bus.SDO_OE[gi] = ~ninp_s[gi];
      assign bus.EMPTY[gi]  = (cnt_reg == CNT_MAX);
    end
  endgenerate
endmodule

// File: tb/tb_famicom_pad_ports.sv
// Directed bench: a default 2-port instance and a 24-bit inverted 1-port instance.
module tb_famicom_pad_ports;
  logic CLK = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  famicom_pad_ports_if #(.NUM_PORTS(2), .SHIFT_LEN(8))  bus_a ();
  famicom_pad_ports_if #(.NUM_PORTS(1), .SHIFT_LEN(24)) bus_b ();

  famicom_pad_ports #(
    .NUM_PORTS(2), .SHIFT_LEN(8), .FILL_BIT(1'b1), .INVERT_OUT(1'b0), .SYNC_STAGES(2)
  ) dut_a (
    .CLK (CLK),
    .nRST(rst_a),
    .bus (bus_a)
  );

  famicom_pad_ports #(
    .NUM_PORTS(1), .SHIFT_LEN(24), .FILL_BIT(1'b1), .INVERT_OUT(1'b1), .SYNC_STAGES(2)
  ) dut_b (
    .CLK (CLK),
    .nRST(rst_b),
    .bus (bus_b)
  );

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic read_a(input int p, input string tag, input logic exp);
    bus_a.nINP[p] = 1'b0;
    step(3);
    check({tag, "_oe"}, 32'(bus_a.SDO_OE[p]), 32'd1);
    check({tag, "_sdo"}, 32'(bus_a.SDO[p]), 32'(exp));
    $display("read %s port=%0d sdo=%0b", tag, p, bus_a.SDO[p]);
    bus_a.nINP[p] = 1'b1;
    step(3);
  endtask

  task automatic read_b(input string tag, input logic exp);
    bus_b.nINP[0] = 1'b0;
    step(3);
    check({tag, "_sdo"}, 32'(bus_b.SDO[0]), 32'(exp));
    $display("read %s port=0 sdo=%0b", tag, bus_b.SDO[0]);
    bus_b.nINP[0] = 1'b1;
    step(3);
  endtask

  task automatic load_a(input logic [15:0] btn);
    bus_a.BTN  = btn;
    bus_a.OUT0 = 1'b1;
    step(3);
    bus_a.OUT0 = 1'b0;
    step(3);
    $display("load a btn=%04h", btn);
  endtask

  initial begin
    logic [7:0] pat;
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.OUT0 = 1'b0; bus_a.nINP = '1; bus_a.BTN = '0;
    bus_b.OUT0 = 1'b0; bus_b.nINP = '1; bus_b.BTN = '0;
    step(1);

    // Reset held with a live strobe and toggling reads
    bus_a.OUT0 = 1'b1;
    bus_a.BTN  = {8'h00, 8'hA5};
    for (int i = 0; i < 6; i++) begin
      bus_a.nINP = ~bus_a.nINP;
      step(1);
      check($sformatf("rst_sdo_%0d", i),   32'(bus_a.SDO),    32'd0);
      check($sformatf("rst_oe_%0d", i),    32'(bus_a.SDO_OE), 32'd0);
      check($sformatf("rst_empty_%0d", i), 32'(bus_a.EMPTY),  32'd0);
    end
    check("rst_b_sdo",   32'(bus_b.SDO),    32'd1);
    check("rst_b_oe",    32'(bus_b.SDO_OE), 32'd0);
    check("rst_b_empty", 32'(bus_b.EMPTY),  32'd0);
    bus_a.nINP = '1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    step(2);
    check("first_load_early", 32'(bus_a.SDO), 32'd0);
    step(1);
    check("first_load", 32'(bus_a.SDO), 32'd1);
    bus_a.OUT0 = 1'b0;
    step(3);

    // Default read-out of A5 on port 0
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      read_a(0, $sformatf("a5_r%0d", i + 1), pat[i]);
      if (i == 6) check("a5_empty_after7", 32'(bus_a.EMPTY), 32'd0);
    end
    check("a5_empty_after8", 32'(bus_a.EMPTY), 32'b01);
    read_a(0, "a5_r9", 1'b1);
    read_a(0, "a5_r10", 1'b1);
    check("a5_empty_after10", 32'(bus_a.EMPTY), 32'b01);

    // Port independence
    load_a({8'hF0, 8'h0F});
    check("ind_load", 32'(bus_a.SDO), 32'b01);
    for (int i = 0; i < 3; i++) read_a(1, $sformatf("ind_p1_r%0d", i + 1), 1'b0);
    read_a(0, "ind_p0_r1", 1'b1);
    check("ind_sdo",   32'(bus_a.SDO),   32'b01);
    check("ind_empty", 32'(bus_a.EMPTY), 32'b00);

    // Load priority with strobe held high
    bus_a.BTN  = {8'h00, 8'h01};
    bus_a.OUT0 = 1'b1;
    step(3);
    for (int i = 0; i < 5; i++) begin
      bus_a.nINP[0] = 1'b0;
      step(3);
      check($sformatf("pri_low_sdo_%0d", i), 32'(bus_a.SDO[0]), 32'd1);
      bus_a.nINP[0] = 1'b1;
      step(3);
      check($sformatf("pri_sdo_%0d", i),   32'(bus_a.SDO[0]),   32'd1);
      check($sformatf("pri_empty_%0d", i), 32'(bus_a.EMPTY[0]), 32'd0);
    end
    // Read edge reaches the shifter in the last cycle the strobe is still high
    bus_a.nINP[0] = 1'b0;
    step(3);
    bus_a.nINP[0] = 1'b1;
    step(1);
    bus_a.OUT0 = 1'b0;
    step(4);
    check("pri_coincident_sdo", 32'(bus_a.SDO[0]), 32'd1);
    read_a(0, "pri_r1", 1'b1);
    for (int i = 2; i <= 8; i++) begin
      read_a(0, $sformatf("pri_r%0d", i), 1'b0);
      if (i == 7) check("pri_empty_after7", 32'(bus_a.EMPTY[0]), 32'd0);
    end
    check("pri_empty_after8", 32'(bus_a.EMPTY[0]), 32'd1);

    // Asynchronous reset in the middle of a read-out
    load_a({8'h00, 8'hFF});
    for (int i = 0; i < 3; i++) read_a(0, $sformatf("mid_r%0d", i + 1), 1'b1);
    check("mid_pre_sdo", 32'(bus_a.SDO[0]), 32'd1);
    rst_a = 1'b0;
    #2;
    check("mid_rst_sdo",   32'(bus_a.SDO),   32'd0);
    check("mid_rst_empty", 32'(bus_a.EMPTY), 32'd0);
    step(1);
    rst_a = 1'b1;
    step(2);
    read_a(0, "mid_post_r1", 1'b0);
    check("mid_post_sdo",   32'(bus_a.SDO[0]),   32'd0);
    check("mid_post_empty", 32'(bus_a.EMPTY[0]), 32'd0);

    // 24-bit inverted instance
    bus_b.BTN  = 24'h000001;
    bus_b.OUT0 = 1'b1;
    step(3);
    bus_b.OUT0 = 1'b0;
    step(3);
    check("b_load_sdo", 32'(bus_b.SDO), 32'd0);
    read_b("b_r1", 1'b0);
    for (int i = 2; i <= 24; i++) begin
      read_b($sformatf("b_r%0d", i), 1'b1);
      if (i == 23) check("b_empty_after23", 32'(bus_b.EMPTY), 32'd0);
    end
    check("b_empty_after24", 32'(bus_b.EMPTY), 32'd1);
    read_b("b_r25", 1'b0);
    check("b_empty_after25", 32'(bus_b.EMPTY), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
